// File: rtl/peri_gpio_axi_slave_if.sv
// AXI4 channel bundle between the peripheral subsystem and the GPIO register slave.
// 64-bit data, one outstanding transaction per direction.
interface peri_gpio_axi_slave_if #(
  parameter int ID_W = 8
) ();
  logic [ID_W-1:0] awid;
  logic [31:0]     awaddr;
  logic [3:0]      awlen;
  logic [2:0]      awsize;
  logic [1:0]      awburst;
  logic            awvalid;
  logic            awready;
  logic [63:0]     wdata;
  logic [7:0]      wstrb;
  logic            wlast;
  logic            wvalid;
  logic            wready;
  logic [ID_W-1:0] bid;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;
  logic [ID_W-1:0] arid;
  logic [31:0]     araddr;
  logic [3:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;
  logic            arvalid;
  logic            arready;
  logic [ID_W-1:0] rid;
  logic [63:0]     rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic            rvalid;
  logic            rready;

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    input  wdata, wstrb, wlast, wvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    input  rready,
    output awready, wready, bid, bresp, bvalid,
    output arready, rid, rdata, rresp, rlast, rvalid
  );

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    output wdata, wstrb, wlast, wvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    output rready,
    input  awready, wready, bid, bresp, bvalid,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/peri_gpio_axi_slave.sv
// AXI4 slave with a four-register GPIO block: synchronized inputs, sticky W1C edge
// status, edge enable, scratch, and a registered level interrupt.
//
//   state  | meaning
//   W_IDLE | awready high, waiting for a write address
//   W_DATA | wready high, each beat applied on handshake until wlast
//   W_RESP | bvalid high, waiting for bready
//   R_IDLE | arready high, waiting for a read address
//   R_DATA | rvalid high with registered beat, advance on rready
module peri_gpio_axi_slave #(
  parameter int NUM_GPIO = 2,
  parameter int ID_W     = 8
) (
  input  logic                i_acr_clk,
  input  logic                i_acr_rst,
  input  logic [NUM_GPIO-1:0] i_gpio_in,
  output logic                o_irq,
  peri_gpio_axi_slave_if.slave s_axi
);
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic       {R_IDLE, R_DATA} rstate_t;

  logic [NUM_GPIO-1:0] r_sync1, r_sync2, r_sync_d, r_status, r_en;
  logic [63:0]         r_scratch;
  logic                r_irq;

  wstate_t         r_wstate;
  logic [ID_W-1:0] r_wid;
  logic [1:0]      r_woff, r_bresp;
  logic            r_wfixed, r_werr;

  rstate_t         r_rstate;
  logic [ID_W-1:0] r_rid;
  logic [1:0]      r_roff, r_rresp;
  logic            r_rfixed, r_rerr, r_rlast;
  logic [3:0]      r_rlen, r_rbeat;
  logic [63:0]     r_rdata;

  logic                w_aw_err, w_ar_err, w_wr_apply, w_rd_err;
  logic [NUM_GPIO-1:0] w_edge, w_st_clr;
  logic [1:0]          w_rd_off;
  logic [63:0]         w_rd_data;
  logic                w_unused;

  assign w_unused = ^{s_axi.awlen, s_axi.awsize, s_axi.arsize, s_axi.awaddr[31:12],
                      s_axi.awaddr[2:0], s_axi.araddr[31:12], s_axi.araddr[2:0]};

  assign w_aw_err   = (s_axi.awaddr[11:5] != 7'd0) | s_axi.awburst[1];
  assign w_ar_err   = (s_axi.araddr[11:5] != 7'd0) | s_axi.arburst[1];
  assign w_edge     = r_sync2 ^ r_sync_d;
  assign w_wr_apply = (r_wstate == W_DATA) & s_axi.wvalid & ~r_werr;
  assign w_st_clr   = (w_wr_apply && r_woff == 2'd1 && s_axi.wstrb[0])
                      ? s_axi.wdata[NUM_GPIO-1:0] : '0;

  // Offset and data of the beat about to be loaded: first beat from AR, else the next one.
  always_comb begin
    w_rd_off  = 2'd0;
    w_rd_err  = 1'b0;
    w_rd_data = '0;
    if (r_rstate == R_IDLE) begin
      w_rd_off = s_axi.araddr[4:3];
      w_rd_err = w_ar_err;
    end else begin
      w_rd_off = r_rfixed ? r_roff : r_roff + 2'd1;
      w_rd_err = r_rerr;
    end
    if (!w_rd_err) begin
      case (w_rd_off)
        2'd0:    w_rd_data = 64'(r_sync2);
        2'd1:    w_rd_data = 64'(r_status);
        2'd2:    w_rd_data = 64'(r_en);
        default: w_rd_data = r_scratch;
      endcase
    end
  end

  always_ff @(posedge i_acr_clk) begin
    if (i_acr_rst) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_sync_d  <= '0;
      r_status  <= '0;
      r_en      <= '0;
      r_scratch <= '0;
      r_irq     <= 1'b0;
    end else begin
      r_sync1  <= i_gpio_in;
      r_sync2  <= r_sync1;
      r_sync_d <= r_sync2;
      // A new edge beats a same-cycle clear.
      r_status <= (r_status & ~w_st_clr) | w_edge;
      r_irq    <= |(r_status & r_en);
      if (w_wr_apply && r_woff == 2'd2 && s_axi.wstrb[0])
        r_en <= s_axi.wdata[NUM_GPIO-1:0];
      if (w_wr_apply && r_woff == 2'd3) begin
        for (int i = 0; i < 8; i++)
          if (s_axi.wstrb[i]) r_scratch[8*i +: 8] <= s_axi.wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge i_acr_clk) begin
    if (i_acr_rst) begin
      r_wstate <= W_IDLE;
      r_wid    <= '0;
      r_woff   <= 2'd0;
      r_wfixed <= 1'b0;
      r_werr   <= 1'b0;
      r_bresp  <= 2'b00;
    end else begin
      case (r_wstate)
        W_IDLE: if (s_axi.awvalid) begin
          r_wid    <= s_axi.awid;
          r_woff   <= s_axi.awaddr[4:3];
          r_wfixed <= (s_axi.awburst == 2'b00);
          r_werr   <= w_aw_err;
          r_wstate <= W_DATA;
        end
        W_DATA: if (s_axi.wvalid) begin
          if (!r_wfixed) r_woff <= r_woff + 2'd1;
          if (s_axi.wlast) begin
            r_bresp  <= r_werr ? 2'b10 : 2'b00;
            r_wstate <= W_RESP;
          end
        end
        default: if (s_axi.bready) r_wstate <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_acr_clk) begin
    if (i_acr_rst) begin
      r_rstate <= R_IDLE;
      r_rid    <= '0;
      r_roff   <= 2'd0;
      r_rfixed <= 1'b0;
      r_rerr   <= 1'b0;
      r_rlen   <= 4'd0;
      r_rbeat  <= 4'd0;
      r_rdata  <= '0;
      r_rresp  <= 2'b00;
      r_rlast  <= 1'b0;
    end else begin
      case (r_rstate)
        R_IDLE: if (s_axi.arvalid) begin
          r_rid    <= s_axi.arid;
          r_roff   <= w_rd_off;
          r_rfixed <= (s_axi.arburst == 2'b00);
          r_rerr   <= w_ar_err;
          r_rlen   <= s_axi.arlen;
          r_rbeat  <= 4'd0;
          r_rdata  <= w_rd_data;
          r_rresp  <= w_ar_err ? 2'b10 : 2'b00;
          r_rlast  <= (s_axi.arlen == 4'd0);
          r_rstate <= R_DATA;
        end
        default: if (s_axi.rready) begin
          if (r_rlast) begin
            r_rlast  <= 1'b0;
            r_rstate <= R_IDLE;
          end else begin
            r_rbeat <= r_rbeat + 4'd1;
            r_roff  <= w_rd_off;
            r_rdata <= w_rd_data;
            r_rlast <= ((r_rbeat + 4'd1) == r_rlen);
          end
        end
      endcase
    end
  end

  // Outputs are forced low for the whole cycle in which reset is asserted.
  assign s_axi.awready = ~i_acr_rst & (r_wstate == W_IDLE);
  assign s_axi.wready  = ~i_acr_rst & (r_wstate == W_DATA);
  assign s_axi.bvalid  = ~i_acr_rst & (r_wstate == W_RESP);
  assign s_axi.bid     = i_acr_rst ? '0 : r_wid;
  assign s_axi.bresp   = i_acr_rst ? 2'b00 : r_bresp;
  assign s_axi.arready = ~i_acr_rst & (r_rstate == R_IDLE);
  assign s_axi.rvalid  = ~i_acr_rst & (r_rstate == R_DATA);
  assign s_axi.rid     = i_acr_rst ? '0 : r_rid;
  assign s_axi.rdata   = i_acr_rst ? '0 : r_rdata;
  assign s_axi.rresp   = i_acr_rst ? 2'b00 : r_rresp;
  assign s_axi.rlast   = ~i_acr_rst & r_rlast;
  assign o_irq         = ~i_acr_rst & r_irq;
endmodule

// File: tb/tb_peri_gpio_axi_slave.sv
// Scoreboard bench for peri_gpio_axi_slave: expected B/R beats queued from a register
// model when requests are driven, popped and compared as the slave responds.
module tb_peri_gpio_axi_slave;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] gpio = 2'b00;
  logic       irq;

  peri_gpio_axi_slave_if #(.ID_W(8)) axi ();

  peri_gpio_axi_slave #(.NUM_GPIO(2), .ID_W(8)) dut (
    .i_acr_clk (clk),
    .i_acr_rst (rst),
    .i_gpio_in (gpio),
    .o_irq     (irq),
    .s_axi     (axi.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } rexp_t;
  typedef struct {
    logic [7:0] id;
    logic [1:0] resp;
  } bexp_t;

  rexp_t rq[$];
  bexp_t bq[$];
  int n_cmp = 0;
  int n_err = 0;

  logic [63:0] m_scratch = '0;
  logic [1:0]  m_en = '0, m_status = '0, m_gpio = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mrd(input logic [1:0] off);
    case (off)
      2'd0:    return {62'd0, m_gpio};
      2'd1:    return {62'd0, m_status};
      2'd2:    return {62'd0, m_en};
      default: return m_scratch;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic aw_send(input logic [7:0] id, input logic [31:0] addr,
                         input logic [1:0] burst, input logic [3:0] len);
    bexp_t e;
    bit got = 1'b0;
    e.id   = id;
    e.resp = ((addr[11:5] != 7'd0) || burst[1]) ? 2'b10 : 2'b00;
    bq.push_back(e);
    axi.awid = id; axi.awaddr = addr; axi.awburst = burst; axi.awlen = len;
    axi.awsize = 3'd3; axi.awvalid = 1'b1;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = axi.awready;
      tick();
    end
    if (!got) chk("aw_timeout", 0, 1);
    axi.awvalid = 1'b0;
    @(negedge clk);
    chk("wready_lat", axi.wready, 1);
    tick();
  endtask

  task automatic w_send(input logic [63:0] data, input logic [7:0] strb, input logic last);
    bit got = 1'b0;
    axi.wdata = data; axi.wstrb = strb; axi.wlast = last; axi.wvalid = 1'b1;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = axi.wready;
      tick();
    end
    if (!got) chk("w_timeout", 0, 1);
    axi.wvalid = 1'b0;
    axi.wlast  = 1'b0;
    if (last) begin
      @(negedge clk);
      chk("bvalid_lat", axi.bvalid, 1);
      tick();
    end
  endtask

  task automatic b_recv();
    bexp_t e;
    bit got = 1'b0;
    axi.bready = 1'b1;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = axi.bvalid;
      if (got) begin
        if (bq.size() == 0) chk("b_unexpected", 1, 0);
        else begin
          e = bq.pop_front();
          chk("bid", axi.bid, e.id);
          chk("bresp", axi.bresp, e.resp);
        end
      end
      tick();
    end
    if (!got) chk("b_timeout", 0, 1);
    axi.bready = 1'b0;
    @(negedge clk);
    chk("awready_back", axi.awready, 1);
    tick();
  endtask

  task automatic rd(input logic [7:0] id, input logic [31:0] addr, input logic [1:0] burst,
                    input logic [3:0] len, input int stall_at, input int abort_at);
    rexp_t e;
    logic [1:0] off = addr[4:3];
    logic err = (addr[11:5] != 7'd0) || burst[1];
    bit got = 1'b0;
    bit stalled = 1'b0;
    int beats = 0;
    int guard = 0;
    for (int b = 0; b <= int'(len); b++) begin
      e.id = id; e.data = err ? 64'd0 : mrd(off);
      e.resp = err ? 2'b10 : 2'b00; e.last = (b == int'(len));
      rq.push_back(e);
      if (burst == 2'b01) off = off + 2'd1;
    end
    axi.arid = id; axi.araddr = addr; axi.arburst = burst; axi.arlen = len;
    axi.arsize = 3'd3; axi.arvalid = 1'b1; axi.rready = 1'b1;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = axi.arready;
      tick();
    end
    if (!got) chk("ar_timeout", 0, 1);
    axi.arvalid = 1'b0;
    @(negedge clk);
    chk("rvalid_lat", axi.rvalid, 1);
    while (rq.size() > 0 && guard < 100) begin
      if (guard > 0) @(negedge clk);
      guard++;
      if (axi.rvalid && axi.rready) begin
        e = rq.pop_front();
        chk("rid", axi.rid, e.id);
        chk("rdata", axi.rdata, e.data);
        chk("rresp", axi.rresp, e.resp);
        chk("rlast", axi.rlast, e.last);
        beats++;
      end
      tick();
      if (beats == abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        chk("rst_rvalid", axi.rvalid, 0);
        chk("rst_arready", axi.arready, 0);
        chk("rst_rdata", axi.rdata, 0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rel_arready", axi.arready, 1);
        chk("rel_rvalid", axi.rvalid, 0);
        tick();
        rq.delete();
        m_scratch = '0; m_en = '0; m_status = '0;
        return;
      end
      if (beats == stall_at && !stalled && rq.size() > 0) begin
        stalled = 1'b1;
        axi.rready = 1'b0;
        for (int s = 0; s < 2; s++) begin
          @(negedge clk);
          chk("stall_rvalid", axi.rvalid, 1);
          chk("stall_rdata", axi.rdata, rq[0].data);
          tick();
        end
        axi.rready = 1'b1;
      end
    end
    if (rq.size() > 0) begin
      chk("r_timeout", 0, 1);
      rq.delete();
    end
    @(negedge clk);
    chk("arready_back", axi.arready, 1);
    tick();
  endtask

  initial begin
    axi.awid = '0; axi.awaddr = '0; axi.awlen = '0; axi.awsize = '0; axi.awburst = '0;
    axi.awvalid = 1'b0; axi.wdata = '0; axi.wstrb = '0; axi.wlast = 1'b0; axi.wvalid = 1'b0;
    axi.bready = 1'b0; axi.arid = '0; axi.araddr = '0; axi.arlen = '0; axi.arsize = '0;
    axi.arburst = '0; axi.arvalid = 1'b0; axi.rready = 1'b0;

    @(negedge clk);
    chk("rst_awready", axi.awready, 0);
    chk("rst_arready", axi.arready, 0);
    chk("rst_irq", irq, 0);
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rel_awready", axi.awready, 1);
    chk("rel_arready", axi.arready, 1);
    tick();

    rd(8'h11, 32'h00, 2'b01, 4'd0, -1, -1);
    chk("irq_idle", irq, 0);

    aw_send(8'h5A, 32'h18, 2'b01, 4'd0);
    w_send(64'hDEADBEEF_01234567, 8'h0F, 1'b1);
    b_recv();
    m_scratch = 64'h00000000_01234567;
    rd(8'h22, 32'h18, 2'b01, 4'd0, -1, -1);

    rd(8'h33, 32'h00, 2'b01, 4'd3, 2, -1);

    aw_send(8'h44, 32'h10, 2'b01, 4'd0);
    w_send(64'h3, 8'hFF, 1'b1);
    b_recv();
    m_en = 2'b11;

    gpio[1] = 1'b1;
    repeat (3) @(negedge clk);
    @(negedge clk);
    chk("irq_n3", irq, 0);
    @(negedge clk);
    chk("irq_n4", irq, 1);
    tick();
    m_gpio = 2'b10; m_status = 2'b10;
    rd(8'h34, 32'h08, 2'b01, 4'd0, -1, -1);
    rd(8'h35, 32'h00, 2'b00, 4'd0, -1, -1);

    aw_send(8'h45, 32'h08, 2'b01, 4'd0);
    gpio[1] = 1'b0;
    tick();
    tick();
    w_send(64'h2, 8'h01, 1'b1);
    b_recv();
    m_gpio = 2'b00;
    rd(8'h36, 32'h08, 2'b01, 4'd0, -1, -1);
    chk("irq_held", irq, 1);

    aw_send(8'h46, 32'h08, 2'b01, 4'd0);
    w_send(64'h2, 8'h01, 1'b1);
    b_recv();
    m_status = 2'b00;
    @(negedge clk);
    chk("irq_cleared", irq, 0);
    tick();
    rd(8'h37, 32'h08, 2'b01, 4'd0, -1, -1);

    aw_send(8'h47, 32'h10, 2'b01, 4'd0);
    w_send(64'h0, 8'hFE, 1'b1);
    b_recv();
    rd(8'h38, 32'h10, 2'b01, 4'd0, -1, -1);

    aw_send(8'h77, 32'h40, 2'b01, 4'd1);
    w_send({64{1'b1}}, 8'hFF, 1'b0);
    w_send({64{1'b1}}, 8'hFF, 1'b1);
    b_recv();
    aw_send(8'h78, 32'h58, 2'b01, 4'd0);
    w_send({64{1'b1}}, 8'hFF, 1'b1);
    b_recv();
    aw_send(8'h79, 32'h18, 2'b10, 4'd0);
    w_send({64{1'b1}}, 8'hFF, 1'b1);
    b_recv();
    rd(8'h7A, 32'h18, 2'b00, 4'd2, -1, -1);
    rd(8'h7B, 32'h00, 2'b10, 4'd1, -1, -1);
    rd(8'h7C, 32'h18, 2'b01, 4'd1, -1, -1);
    rd(8'h7D, 32'h800, 2'b01, 4'd0, -1, -1);

    rd(8'h7E, 32'h00, 2'b01, 4'd3, -1, 2);
    rd(8'h7F, 32'h18, 2'b01, 4'd0, -1, -1);
    rd(8'h80, 32'h10, 2'b01, 4'd0, -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/peri_gpio_axi_slave.md
# peri_gpio_axi_slave

AXI4 slave terminating the peripheral-subsystem AXI port and exposing a small GPIO register block: synchronized input sampling, per-pin edge detection, sticky W1C status and a level interrupt. It sits directly downstream of the peripheral subsystem boundary, consuming its AXI write/read channels and its raw `gpio_*` inputs. It supports one outstanding write and one outstanding read, with INCR/FIXED bursts of up to 16 beats.

## Interface
- `NUM_GPIO`, 2: number of GPIO inputs (1..8).
- `ID_W`, 8: AXI ID width.
- `acr_clk`  in  1  sole clock.
- `acr_rst`  in  1  reset; synchronous, active-high.
- `axi_aw{id,addr,len,size,burst,valid}`  in  `ID_W`/32/4/3/2/1  write address; `awready` out 1.
- `axi_w{data,strb,last,valid}`  in  64/8/1/1  write data; `wready` out 1.
- `axi_b{id,resp,valid}`  out  `ID_W`/2/1  write response; `bready` in 1.
- `axi_ar{id,addr,len,size,burst,valid}`  in  `ID_W`/32/4/3/2/1  read address; `arready` out 1.
- `axi_r{id,data,resp,last,valid}`  out  `ID_W`/64/2/1/1  read data; `rready` in 1.
- `gpio_in`  in  `NUM_GPIO`  asynchronous pin inputs.
- `irq`  out  1  `|(EDGE_STATUS & EDGE_EN)`, registered.

## Operation
- Register map, offset `addr[4:3]`, block valid when `addr[11:5]==0`:
  - 0x00 `GPIO_IN` (RO): 2-flop synchronized pins in bits [NUM_GPIO-1:0], 0 elsewhere.
  - 0x08 `EDGE_STATUS` (W1C): bit set on any synchronized transition.
  - 0x10 `EDGE_EN` (RW, NUM_GPIO bits).
  - 0x18 `SCRATCH` (RW, 64 bits, byte strobes honoured).
- `GPIO_IN`, `EDGE_STATUS` and `EDGE_EN` writes take effect only when `wstrb[0]`=1. Writes to `GPIO_IN` are ignored and respond OKAY.
- Address outside the block, or `burst`=WRAP/reserved: the whole burst is accepted with no register effect. The response is SLVERR (2'b10): one `bresp` for writes, every read beat `rresp`=SLVERR with `rdata`=0.
- Beat addressing: FIXED holds the address. INCR adds 8 per beat (`size` ignored, 64-bit beats). Offset bits wrap modulo 0x20, and the valid check uses the start address only.
- Write FSM: W_IDLE (`awready`=1) -> AW handshake latches id/addr/burst/error -> W_DATA (`wready`=1, each beat applied on handshake) -> beat with `wlast`=1 -> W_RESP (`bvalid`=1) -> `bready` -> W_IDLE. Beats are counted by `wlast` only; `awlen` is not checked.
- Read FSM: R_IDLE (`arready`=1) -> AR handshake -> R_DATA. `rdata` is registered and `rvalid`=1 the next cycle. Each R handshake loads the next beat. `rlast`=1 when beat count == `arlen`; handshake on last -> R_IDLE.
- Read and write FSMs are independent and may be active in the same cycle.
- Same-cycle W1C of an `EDGE_STATUS` bit and a new edge on that pin: the set wins (bit = 1).
- Edge detection compares the synchronized value with its 1-cycle delayed copy. The delayed copy resets to 0, so a pin high at reset release records one rising edge.

## Timing
- During reset, and for that whole cycle, all outputs are 0: `awready`, `wready`, `bvalid`, `arready`, `rvalid`, `rlast`, `irq`, ids, resp, `rdata`. Registers and synchronizers also reset to 0.
- First cycle after `acr_rst` deasserts: `awready`=`arready`=1.
- Write latency:
  - AW handshake at cycle N: `wready`=1 at N+1.
  - Last W handshake at cycle M: `bvalid`=1 at M+1.
  - B handshake at cycle K: `awready`=1 at K+1.
- Read latency:
  - AR handshake at cycle N: first beat `rvalid` at N+1.
  - Back-to-back beats every cycle while `rready`=1.
  - `arready`=1 again the cycle after the last R handshake.
- Pin to status: pin change at cycle N sets `EDGE_STATUS` at N+3; `irq` follows at N+4 if enabled.
- Written value is visible to a read beat issued at least one cycle after the W handshake.
- `bvalid`/`rvalid` and their payloads hold stable until accepted (AXI rule).
- Reset mid-burst aborts immediately; no response is issued afterwards.

## Test plan
- After reset, with `gpio_in`=0: read 0x00 len 0 -> `rdata`=0, `rresp`=OKAY, `rlast`=1 one cycle after AR handshake; `irq`=0.
- Write `SCRATCH` 0xDEADBEEF_01234567 with `wstrb`=0x0F, then read it back -> 0x00000000_01234567; `bid`=`awid`=0x5A.
- INCR read from 0x00 with len 3 -> 4 beats at GPIO_IN, STATUS, EN, SCRATCH; `rlast` only on beat 4; hold `rready`=0 for 2 cycles mid-burst -> data stable.
- Set `EDGE_EN`=0x3, toggle `gpio_in[1]` -> `STATUS`=0x2, `irq` 4 cycles after the toggle. Write 0x2 to STATUS in the same cycle as a new edge on pin 1 -> STATUS stays 0x2; clear with no edge -> `irq` drops.
- Write to 0x40 (len 1) -> 2 beats accepted, `bresp`=SLVERR, no register change. Read with WRAP -> SLVERR on every beat.
- Assert `acr_rst` during a 4-beat read after beat 2 -> `rvalid`=0 in reset; `arready`=1 the first cycle after release.
